// File: rtl/time_entry_loader.sv
// time_entry_loader: keypad-side writer for the microwave countdown chain.
// Collects up to four BCD digits (MM:SS), pulses the chain's active-low
// parallel load, then holds the count enable until done or CLEAR.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | no digits entered, waiting for the first digit
//   S_ENTRY | one to four digits held in data, waiting for START/CLEAR
//   S_LOAD  | loadn low this cycle, chain captures data
//   S_RUN   | run_en high, counting down until done or CLEAR
module time_entry_loader #(
    parameter logic [3:0] KEY_CLEAR    = 4'd10,
    parameter logic [3:0] KEY_START    = 4'd11,
    parameter logic [3:0] MAX_SEC_TENS = 4'd5
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        done,
    output logic [15:0] data,
    output logic        loadn,
    output logic        run_en,
    output logic        abort,
    output logic        err,
    output logic [2:0]  digit_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_LOAD, S_RUN} state_t;

    state_t      state_q, state_d;
    logic [15:0] data_q, data_d;
    logic [2:0]  digit_cnt_q, digit_cnt_d;
    logic        loadn_q, loadn_d;
    logic        run_en_q, run_en_d;
    logic        abort_q, abort_d;
    logic        err_q, err_d;

    logic key_digit, key_clear, key_start, room_left, start_ok;

    assign key_digit = key_valid && (key_code <= 4'd9);
    assign key_clear = key_valid && (key_code == KEY_CLEAR);
    assign key_start = key_valid && (key_code == KEY_START);
    assign room_left = digit_cnt_q < 3'd4;
    // An all-zero entry or a seconds-tens digit above the limit is rejected.
    assign start_ok  = (data_q != 16'd0) && (data_q[7:4] <= MAX_SEC_TENS);

    // State and registered outputs; clr wins over everything else.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= S_IDLE;
            data_q      <= 16'd0;
            digit_cnt_q <= 3'd0;
            loadn_q     <= 1'b1;
            run_en_q    <= 1'b0;
            abort_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            digit_cnt_q <= digit_cnt_d;
            loadn_q     <= loadn_d;
            run_en_q    <= run_en_d;
            abort_q     <= abort_d;
            err_q       <= err_d;
        end
    end

    // Next-state selection from the current state and the sampled key/done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (key_digit && room_left) state_d = S_ENTRY;
            end
            S_ENTRY: begin
                if (key_clear)                  state_d = S_IDLE;
                else if (key_start && start_ok) state_d = S_LOAD;
            end
            S_LOAD: state_d = S_RUN;
            S_RUN: begin
                if (done || key_clear) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; loadn and run_en are driven in
    // separate states so they can never be active together.
    always_comb begin
        data_d      = data_q;
        digit_cnt_d = digit_cnt_q;
        loadn_d     = 1'b1;
        run_en_d    = 1'b0;
        abort_d     = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE, S_ENTRY: begin
                if (key_digit) begin
                    if (room_left) begin
                        data_d      = {data_q[11:0], key_code};
                        digit_cnt_d = digit_cnt_q + 3'd1;
                    end
                end else if (key_clear && state_q == S_ENTRY) begin
                    data_d      = 16'd0;
                    digit_cnt_d = 3'd0;
                end else if (key_start && state_q == S_ENTRY) begin
                    if (start_ok) loadn_d = 1'b0;
                    else          err_d   = 1'b1;
                end
            end
            S_LOAD: run_en_d = 1'b1;
            S_RUN: begin
                if (done) begin
                    data_d      = 16'd0;
                    digit_cnt_d = 3'd0;
                end else if (key_clear) begin
                    abort_d     = 1'b1;
                    data_d      = 16'd0;
                    digit_cnt_d = 3'd0;
                end else begin
                    run_en_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign data      = data_q;
    assign digit_cnt = digit_cnt_q;
    assign loadn     = loadn_q;
    assign run_en    = run_en_q;
    assign abort     = abort_q;
    assign err       = err_q;

endmodule

// File: tb/tb_time_entry_loader.sv
// Bench for time_entry_loader: directed scenarios followed by random key
// traffic, all compared against a digit-queue reference model.
module tb_time_entry_loader;

    logic        clk = 1'b0;
    logic        clr, key_valid, done;
    logic [3:0]  key_code;
    logic [15:0] data;
    logic        loadn, run_en, abort, err;
    logic [2:0]  digit_cnt;

    time_entry_loader dut (
        .clk       (clk),
        .clr       (clr),
        .key_valid (key_valid),
        .key_code  (key_code),
        .done      (done),
        .data      (data),
        .loadn     (loadn),
        .run_en    (run_en),
        .abort     (abort),
        .err       (err),
        .digit_cnt (digit_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the entered digits as a queue plus a coarse phase
    // (0 = entering/idle, 1 = loading, 2 = counting).
    int          digits[$];
    int          phase = 0;
    logic [15:0] e_data;
    int          e_cnt;
    logic        e_loadn, e_run, e_abort, e_err;

    function automatic logic [15:0] entry_value();
        int v = 0;
        foreach (digits[i]) v = v * 16 + digits[i];
        return v[15:0];
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic c, input logic kv, input logic [3:0] kc, input logic dn);
        bit          is_dig, is_clr, is_st;
        logic [15:0] v;
        is_dig  = kv && (kc <= 4'd9);
        is_clr  = kv && (kc == 4'd10);
        is_st   = kv && (kc == 4'd11);
        e_abort = 1'b0;
        e_err   = 1'b0;
        e_loadn = 1'b1;
        e_run   = 1'b0;
        if (c) begin
            digits.delete();
            phase = 0;
        end else begin
            case (phase)
                0: begin
                    if (is_dig) begin
                        if (digits.size() < 4) digits.push_back(int'(kc));
                    end else if (is_clr) begin
                        digits.delete();
                    end else if (is_st && digits.size() > 0) begin
                        v = entry_value();
                        if (v == 16'd0 || v[7:4] > 4'd5) e_err = 1'b1;
                        else begin
                            phase   = 1;
                            e_loadn = 1'b0;
                        end
                    end
                end
                1: begin
                    phase = 2;
                    e_run = 1'b1;
                end
                default: begin
                    if (dn) begin
                        digits.delete();
                        phase = 0;
                    end else if (is_clr) begin
                        e_abort = 1'b1;
                        digits.delete();
                        phase = 0;
                    end else begin
                        e_run = 1'b1;
                    end
                end
            endcase
        end
        e_data = entry_value();
        e_cnt  = digits.size();
    endtask

    task automatic cycle(input logic c, input logic kv, input logic [3:0] kc, input logic dn);
        clr       = c;
        key_valid = kv;
        key_code  = kc;
        done      = dn;
        model_step(c, kv, kc, dn);
        @(posedge clk);
        #1;
        check_val("data",      32'(data),      32'(e_data));
        check_val("digit_cnt", 32'(digit_cnt), 32'(e_cnt));
        check_val("loadn",     32'(loadn),     32'(e_loadn));
        check_val("run_en",    32'(run_en),    32'(e_run));
        check_val("abort",     32'(abort),     32'(e_abort));
        check_val("err",       32'(err),       32'(e_err));
        check_val("no_load_while_run", 32'(!loadn && run_en), 32'd0);
    endtask

    task automatic key(input logic [3:0] kc);
        cycle(1'b0, 1'b1, kc, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        clr = 1'b1; key_valid = 1'b0; key_code = 4'd0; done = 1'b0;
        #1;

        // Reset with a key pending: key must not be captured.
        cycle(1'b1, 1'b1, 4'd3, 1'b0);
        cycle(1'b1, 1'b1, 4'd3, 1'b0);
        check_val("rst_data", 32'(data), 32'h0);
        check_val("rst_loadn", 32'(loadn), 32'h1);
        idle(1);

        // 1,3,0 START -> load 0130, run, done.
        key(4'd1); idle(1); key(4'd3); key(4'd0);
        check_val("entry_0130", 32'(data), 32'h0130);
        check_val("cnt_3", 32'(digit_cnt), 32'd3);
        key(4'd11);
        check_val("loadn_low", 32'(loadn), 32'd0);
        idle(1);
        check_val("run_after_load", 32'(run_en), 32'd1);
        check_val("loadn_high_again", 32'(loadn), 32'd1);
        idle(3);
        key(4'd5); key(4'd11);
        cycle(1'b0, 1'b0, 4'd0, 1'b1);
        check_val("done_run_off", 32'(run_en), 32'd0);
        check_val("done_no_abort", 32'(abort), 32'd0);
        idle(1);

        // Fifth digit dropped.
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
        check_val("entry_1234", 32'(data), 32'h1234);
        check_val("cnt_4", 32'(digit_cnt), 32'd4);
        key(4'd10);
        key(4'd13);

        // Illegal seconds tens -> err; then START in IDLE is ignored.
        key(4'd0); key(4'd7); key(4'd5); key(4'd11);
        check_val("err_pulse", 32'(err), 32'd1);
        idle(1);
        check_val("err_one_cycle", 32'(err), 32'd0);
        key(4'd10); key(4'd11);
        check_val("idle_start_no_err", 32'(err), 32'd0);
        key(4'd0); key(4'd0); key(4'd11);
        check_val("zero_entry_err", 32'(err), 32'd1);
        key(4'd10);

        // RUN then CLEAR -> abort; then CLEAR together with done -> no abort.
        key(4'd1); key(4'd0); key(4'd0); key(4'd11); idle(2);
        key(4'd10);
        check_val("abort_pulse", 32'(abort), 32'd1);
        idle(1);
        key(4'd2); key(4'd11); idle(2);
        cycle(1'b0, 1'b1, 4'd10, 1'b1);
        check_val("clear_done_no_abort", 32'(abort), 32'd0);
        idle(1);

        // clr during the LOAD cycle.
        key(4'd5); key(4'd11);
        cycle(1'b1, 1'b0, 4'd0, 1'b0);
        check_val("clr_load_loadn", 32'(loadn), 32'd1);
        idle(2);
        check_val("clr_load_run", 32'(run_en), 32'd0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            logic       c, kv, dn;
            logic [3:0] kc;
            int         r;
            c  = ($urandom_range(0, 299) == 0);
            kv = ($urandom_range(0, 2) == 0);
            r  = $urandom_range(0, 19);
            if (r < 12)      kc = 4'($urandom_range(0, 9));
            else if (r < 15) kc = 4'd11;
            else if (r < 17) kc = 4'd10;
            else             kc = 4'($urandom_range(12, 15));
            dn = ($urandom_range(0, 14) == 0);
            cycle(c, kv, kc, dn);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
